mem_port_arbiter: RTL

Shares the single 8-bit program/data memory port between three requesters: instruction fetch (req0), LOAD/STORE data access (req1) and the program loader (req2).
- Sits between the control unit / loader and the memory macro.
- Uses a valid/ready request handshake and a one-cycle read-response pulse.
- Memory is synchronous: read data is valid the cycle after the memory is enabled.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_select.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings, requester indices and helpers for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA  = 2'd1;
    localparam logic [1:0] REQ_LOAD  = 2'd2;

    // Only the program loader may be served while booting.
    localparam logic [NUM_REQ-1:0] BOOT_ELIG_MASK = 3'b100;

    // Requester index that follows i in the round-robin ring.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == REQ_LOAD) ? REQ_FETCH : i + 2'd1;
    endfunction

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - combinational winner selection (fixed priority, or round-robin with `define MEM_ARB_RR_EN)
module arb_select
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         idx
);

`ifdef MEM_ARB_RR_EN
    logic [1:0] cand;

    // Walk the ring from the pointer and take the first eligible requester.
    always_comb begin
        grant = '0;
        idx   = REQ_FETCH;
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == '0 && elig[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
            end
            cand = next_idx(cand);
        end
    end
`else
    // The pointer has no meaning under fixed priority.
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Fixed priority: loader beats data access beats instruction fetch.
    always_comb begin
        grant = '0;
        idx   = REQ_FETCH;
        if (elig[REQ_LOAD]) begin
            grant[REQ_LOAD] = 1'b1;
            idx             = REQ_LOAD;
        end else if (elig[REQ_DATA]) begin
            grant[REQ_DATA] = 1'b1;
            idx             = REQ_DATA;
        end else if (elig[REQ_FETCH]) begin
            grant[REQ_FETCH] = 1'b1;
            idx              = REQ_FETCH;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory port between fetch, data and loader requesters; `define MEM_ARB_RR_EN for round-robin
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_mode,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,

    input  logic              req2_valid,
    input  logic              req2_we,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [DATA_W-1:0] req2_wdata,
    output logic              req2_ready,
    output logic              req2_rvalid,
    output logic [DATA_W-1:0] req2_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              cpu_stall
);

    arb_state_t          state, state_nxt;
    logic [NUM_REQ-1:0]  valid_v, we_v, elig, grant, ready_v, rvalid_v;
    logic [ADDR_W-1:0]   addr_v  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_v [NUM_REQ];
    logic [DATA_W-1:0]   rdata_q [NUM_REQ];
    logic [1:0]          gidx, win_idx, rr_ptr;

    assign valid_v    = {req2_valid, req1_valid, req0_valid};
    assign we_v       = {req2_we, req1_we, req0_we};
    assign addr_v[0]  = req0_addr;
    assign addr_v[1]  = req1_addr;
    assign addr_v[2]  = req2_addr;
    assign wdata_v[0] = req0_wdata;
    assign wdata_v[1] = req1_wdata;
    assign wdata_v[2] = req2_wdata;

    assign elig = boot_mode ? (valid_v & BOOT_ELIG_MASK) : valid_v;

    arb_select u_arb_select (
        .elig  (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the per-state strobes (ready in ARB, mem_en in ACCESS, rvalid in RESP).
    always_comb begin
        state_nxt = state;
        ready_v   = '0;
        rvalid_v  = '0;
        mem_en    = 1'b0;
        case (state)
            ARB: begin
                if (rst_n) begin
                    ready_v = grant;
                end
                if (|grant) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (!mem_we) begin
                    rvalid_v[win_idx] = 1'b1;
                end
                state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    // Latch the winner's command on grant; keep each requester's last read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            win_idx   <= REQ_FETCH;
            for (int i = 0; i < NUM_REQ; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            if (state == ARB && |grant) begin
                mem_we    <= we_v[gidx];
                mem_addr  <= addr_v[gidx];
                mem_wdata <= wdata_v[gidx];
                win_idx   <= gidx;
            end
            if (state == RESP && !mem_we) begin
                rdata_q[win_idx] <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin search origin: one past the most recent winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= REQ_FETCH;
        end else if (state == ARB && |grant) begin
            rr_ptr <= next_idx(gidx);
        end
    end
`else
    assign rr_ptr = REQ_FETCH;
`endif

    assign req0_ready  = ready_v[0];
    assign req1_ready  = ready_v[1];
    assign req2_ready  = ready_v[2];
    assign req0_rvalid = rvalid_v[0];
    assign req1_rvalid = rvalid_v[1];
    assign req2_rvalid = rvalid_v[2];

    // During the response cycle the memory output is forwarded directly.
    assign req0_rdata = rvalid_v[0] ? mem_rdata : rdata_q[0];
    assign req1_rdata = rvalid_v[1] ? mem_rdata : rdata_q[1];
    assign req2_rdata = rvalid_v[2] ? mem_rdata : rdata_q[2];

    assign cpu_stall = boot_mode | ((state != ARB) && (win_idx == REQ_LOAD));

endmodule
